adam_mmap_decoder: RTL and testbench

- Runtime-programmable address-map decoder. Takes a bus address and returns the matching region index plus the sub-slot inside that region.
- The table defaults at reset to parameterised start/end/increment windows. It generalises the static package map to N regions, writable entries, a lock, and a pipelined valid/ready interface.
- Sits in front of the fabric demux: one instance per fabric master port.

---
 rtl/adam_mmap_decoder_if.sv | 26 ++
 rtl/adam_mmap_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_adam_mmap_decoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adam_mmap_decoder_if.sv
// Request/response handshake bundle for adam_mmap_decoder.
// master = address source / response sink, slave = the decoder.
interface adam_mmap_decoder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REGION_W   = 3,
  parameter int SLOT_W     = 4
);
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic                  req_ready;
  logic [REGION_W-1:0]   rsp_region;
  logic [SLOT_W-1:0]     rsp_slot;
  logic                  rsp_hit;
  logic                  rsp_valid;
  logic                  rsp_ready;

  modport master (
    output req_addr, req_valid, rsp_ready,
    input  req_ready, rsp_region, rsp_slot, rsp_hit, rsp_valid
  );

  modport slave (
    input  req_addr, req_valid, rsp_ready,
    output req_ready, rsp_region, rsp_slot, rsp_hit, rsp_valid
  );
endinterface

// File: rtl/adam_mmap_decoder.sv
// Runtime-programmable address-map decoder: 2-stage pipeline, lockable table.
// Optional sticky miss log enabled by defining ADAM_MMAP_MISS_LOG_EN.
module adam_mmap_decoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int NO_REGIONS = 8,
  parameter int MAX_SLOTS  = 16,
  parameter logic [NO_REGIONS*ADDR_WIDTH-1:0] RST_START = '0,
  parameter logic [NO_REGIONS*ADDR_WIDTH-1:0] RST_END   = '0,
  parameter logic [NO_REGIONS*5-1:0]          RST_SHIFT = '0,
  parameter logic [NO_REGIONS-1:0]            RST_SPLIT = '0,
  parameter int REGION_W = (NO_REGIONS > 1) ? $clog2(NO_REGIONS) : 1,
  parameter int SLOT_W   = (MAX_SLOTS  > 1) ? $clog2(MAX_SLOTS)  : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  adam_mmap_decoder_if.slave    bus,
  input  logic                  cfg_we,
  input  logic [REGION_W-1:0]   cfg_idx,
  input  logic [1:0]            cfg_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata,
  input  logic                  cfg_lock,
  output logic                  locked,
  output logic                  cfg_err,
  output logic                  miss_flag,
  output logic [ADDR_WIDTH-1:0] miss_addr
);

  logic [NO_REGIONS-1:0][ADDR_WIDTH-1:0] start_q, start_d, end_q, end_d;
  logic [NO_REGIONS-1:0][4:0]            shift_q, shift_d;
  logic [NO_REGIONS-1:0]                 split_q, split_d;
  logic locked_q, locked_d, cfg_err_q, cfg_err_d;
  logic tbl_wr;

  logic                                  s1_valid_q, s1_valid_d;
  logic [NO_REGIONS-1:0]                 s1_match_q, s1_match_d;
  logic [NO_REGIONS-1:0][ADDR_WIDTH-1:0] s1_off_q, s1_off_d;
  logic [NO_REGIONS-1:0][4:0]            s1_shift_q, s1_shift_d;
  logic [NO_REGIONS-1:0]                 s1_split_q, s1_split_d;

  logic                rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic [REGION_W-1:0] rsp_region_q, rsp_region_d;
  logic [SLOT_W-1:0]   rsp_slot_q, rsp_slot_d;

  logic                  s1_adv, req_rdy;
  logic                  sel_hit, sel_split, s2_hit;
  logic [REGION_W-1:0]   sel_idx;
  logic [ADDR_WIDTH-1:0] sel_off, slot_full;
  logic [4:0]            sel_shift;

  // Table writes; a write issued together with cfg_lock still lands.
  always_comb begin
    start_d   = start_q;
    end_d     = end_q;
    shift_d   = shift_q;
    split_d   = split_q;
    cfg_err_d = 1'b0;
    locked_d  = locked_q || cfg_lock;
    tbl_wr    = cfg_we && (cfg_sel != 2'd3);
    if (tbl_wr) begin
      if (locked_q || (int'(cfg_idx) >= NO_REGIONS)) begin
        cfg_err_d = 1'b1;
      end else begin
        case (cfg_sel)
          2'd0:    start_d[cfg_idx] = cfg_wdata;
          2'd1:    end_d[cfg_idx]   = cfg_wdata;
          default: begin
            split_d[cfg_idx] = cfg_wdata[5];
            shift_d[cfg_idx] = cfg_wdata[4:0];
          end
        endcase
      end
    end
  end

  // S1: per-entry compare; shift/split are captured so later writes can't alter in-flight decode.
  always_comb begin
    s1_adv     = !rsp_valid_q || bus.rsp_ready;
    req_rdy    = !s1_valid_q || s1_adv;
    s1_valid_d = s1_valid_q;
    s1_match_d = s1_match_q;
    s1_off_d   = s1_off_q;
    s1_shift_d = s1_shift_q;
    s1_split_d = s1_split_q;
    if (req_rdy) begin
      s1_valid_d = bus.req_valid;
      s1_shift_d = shift_q;
      s1_split_d = split_q;
      for (int i = 0; i < NO_REGIONS; i++) begin
        s1_match_d[i] = bus.req_valid && (start_q[i] < end_q[i]) &&
                        (bus.req_addr >= start_q[i]) &&
                        ((bus.req_addr < end_q[i]) || (&end_q[i]));
        s1_off_d[i]   = bus.req_addr - start_q[i];
      end
    end
  end

  // S2: lowest index wins, so scan downwards and let later hits overwrite.
  always_comb begin
    sel_hit   = 1'b0;
    sel_idx   = '0;
    sel_off   = '0;
    sel_shift = '0;
    sel_split = 1'b0;
    for (int i = NO_REGIONS-1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        sel_hit   = 1'b1;
        sel_idx   = REGION_W'(i);
        sel_off   = s1_off_q[i];
        sel_shift = s1_shift_q[i];
        sel_split = s1_split_q[i];
      end
    end
    slot_full = sel_split ? (sel_off >> sel_shift) : '0;
    s2_hit    = s1_valid_q && sel_hit && (slot_full < ADDR_WIDTH'(MAX_SLOTS));

    rsp_valid_d  = rsp_valid_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_region_d = rsp_region_q;
    rsp_slot_d   = rsp_slot_q;
    if (s1_adv) begin
      rsp_valid_d  = s1_valid_q;
      rsp_hit_d    = s2_hit;
      rsp_region_d = s2_hit ? sel_idx : '0;
      rsp_slot_d   = s2_hit ? slot_full[SLOT_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= RST_START;
      end_q        <= RST_END;
      shift_q      <= RST_SHIFT;
      split_q      <= RST_SPLIT;
      locked_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_match_q   <= '0;
      s1_off_q     <= '0;
      s1_shift_q   <= '0;
      s1_split_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_region_q <= '0;
      rsp_slot_q   <= '0;
    end else begin
      start_q      <= start_d;
      end_q        <= end_d;
      shift_q      <= shift_d;
      split_q      <= split_d;
      locked_q     <= locked_d;
      cfg_err_q    <= cfg_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_match_q   <= s1_match_d;
      s1_off_q     <= s1_off_d;
      s1_shift_q   <= s1_shift_d;
      s1_split_q   <= s1_split_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_region_q <= rsp_region_d;
      rsp_slot_q   <= rsp_slot_d;
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_region = rsp_region_q;
  assign bus.rsp_slot   = rsp_slot_q;
  assign locked         = locked_q;
  assign cfg_err        = cfg_err_q;

`ifdef ADAM_MMAP_MISS_LOG_EN
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d, rsp_addr_q, rsp_addr_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                  miss_flag_q, miss_flag_d;

  // Clear applies first so a miss in the same cycle is still captured.
  always_comb begin
    s1_addr_d   = req_rdy ? bus.req_addr : s1_addr_q;
    rsp_addr_d  = s1_adv ? s1_addr_q : rsp_addr_q;
    miss_flag_d = miss_flag_q;
    miss_addr_d = miss_addr_q;
    if (cfg_we && (cfg_sel == 2'd3)) begin
      miss_flag_d = 1'b0;
      miss_addr_d = '0;
    end
    if (rsp_valid_q && bus.rsp_ready && !rsp_hit_q && !miss_flag_d) begin
      miss_flag_d = 1'b1;
      miss_addr_d = rsp_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_addr_q   <= '0;
      rsp_addr_q  <= '0;
      miss_flag_q <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      s1_addr_q   <= s1_addr_d;
      rsp_addr_q  <= rsp_addr_d;
      miss_flag_q <= miss_flag_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign miss_flag = miss_flag_q;
  assign miss_addr = miss_addr_q;
`else
  assign miss_flag = 1'b0;
  assign miss_addr = '0;
`endif

endmodule

// File: tb/tb_adam_mmap_decoder.sv
// Directed bench for adam_mmap_decoder: default-map vector table plus
// hand sequences for streaming, stalls, config/lock, reset flush and miss log.
module tb_adam_mmap_decoder;
  localparam int AW = 32, NR = 6, MS = 16, RW = 3, SW = 4;
  localparam logic [NR*AW-1:0] RS  = {128'h0, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NR*AW-1:0] RE  = {128'h0, 32'h0001_8000, 32'h0000_8000};
  localparam logic [NR*5-1:0]  RSH = {20'h0, 5'd10, 5'd0};
  localparam logic [NR-1:0]    RSP = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_we = 1'b0, cfg_lock = 1'b0;
  logic [RW-1:0] cfg_idx = '0;
  logic [1:0]    cfg_sel = '0;
  logic [AW-1:0] cfg_wdata = '0;
  logic          locked, cfg_err, miss_flag;
  logic [AW-1:0] miss_addr;

  adam_mmap_decoder_if #(.ADDR_WIDTH(AW), .REGION_W(RW), .SLOT_W(SW)) bus ();

  adam_mmap_decoder #(
    .ADDR_WIDTH(AW), .NO_REGIONS(NR), .MAX_SLOTS(MS),
    .RST_START(RS), .RST_END(RE), .RST_SHIFT(RSH), .RST_SPLIT(RSP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cfg_lock(cfg_lock), .locked(locked), .cfg_err(cfg_err),
    .miss_flag(miss_flag), .miss_addr(miss_addr)
  );

  int checks = 0;
  int errors = 0;

  // Response packed as {hit, region[2:0], slot[3:0]}.
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] cur_rsp();
    return {bus.rsp_hit, bus.rsp_region, bus.rsp_slot};
  endfunction

  task automatic do_req(input logic [31:0] a, output logic [7:0] r, output int lat);
    int n;
    n = 0;
    bus.req_addr = a; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    #1;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = cur_rsp();
  endtask

  task automatic req_chk(input string nm, input logic [31:0] a, input logic [7:0] exp);
    logic [7:0] r; int lat;
    do_req(a, r, lat);
    chk(nm, {24'h0, r}, {24'h0, exp});
  endtask

  task automatic cfg_wr(input logic [2:0] idx, input logic [1:0] sel, input logic [31:0] d,
                        input logic lk, output logic err);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = d; cfg_lock = lk;
    @(posedge clk); #1;
    err = cfg_err;
    cfg_we = 1'b0; cfg_lock = 1'b0;
  endtask

  // Streaming driver: presents s_addr[0..s_n-1] back to back, rsp_ready from s_rdy[c].
  logic [31:0] s_addr [8];
  int          s_n;
  logic [15:0] s_rdy;
  logic [7:0]  s_rsp [$];
  int          s_rcyc [$];
  logic        s_rr [16];
  int          s_acc [16];
  int          s_unstable;

  task automatic stream(input int ncyc);
    int idx; logic [7:0] prev; logic pstall, fire;
    idx = 0; prev = '0; pstall = 1'b0; s_unstable = 0;
    s_rsp.delete(); s_rcyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      bus.req_valid = (idx < s_n);
      bus.req_addr  = s_addr[idx % 8];
      bus.rsp_ready = s_rdy[c];
      #1;
      s_rr[c] = bus.req_ready; s_acc[c] = idx;
      if (pstall && (!bus.rsp_valid || cur_rsp() != prev)) s_unstable++;
      if (bus.rsp_valid && bus.rsp_ready) begin s_rsp.push_back(cur_rsp()); s_rcyc.push_back(c); end
      pstall = bus.rsp_valid && !bus.rsp_ready;
      prev   = cur_rsp();
      fire   = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt [10];
    logic [7:0] r; int lat, nv; logic err;
    vt[0] = '{32'h0001_0C04, 8'h93};
    vt[1] = '{32'h0000_7FFC, 8'h80};
    vt[2] = '{32'h0000_9000, 8'h00};
    vt[3] = '{32'h0001_4000, 8'h00};   // slot 16 >= MAX_SLOTS
    vt[4] = '{32'h0001_0000, 8'h90};
    vt[5] = '{32'h0001_3FFF, 8'h9F};   // last legal slot
    vt[6] = '{32'h0000_8000, 8'h00};   // end is exclusive
    vt[7] = '{32'h0000_0000, 8'h80};
    vt[8] = '{32'h0001_8000, 8'h00};
    vt[9] = '{32'hFFFF_FFFF, 8'h00};

    bus.req_addr = '0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;

    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp", {23'h0, bus.rsp_valid, cur_rsp()}, 32'h0);
    chk("rst_flags", {29'h0, locked, cfg_err, miss_flag}, 32'h0);
    chk("rst_miss_addr", miss_addr, 32'h0);

    for (int i = 0; i < 10; i++) begin
      do_req(vt[i].addr, r, lat);
      chk($sformatf("vec%0d", i), {24'h0, r}, {24'h0, vt[i].exp});
      chk($sformatf("vec%0d_lat", i), lat, 2);
    end
    @(posedge clk); #1;

    // back-to-back with rsp_ready high
    s_addr[0] = 32'h0001_0000; s_addr[1] = 32'h0001_0400;
    s_addr[2] = 32'h0001_0800; s_addr[3] = 32'h0000_0100;
    s_n = 4; s_rdy = 16'hFFFF;
    stream(8);
    chk("b2b_count", s_rsp.size(), 4);
    if (s_rsp.size() == 4) begin
      chk("b2b_r0", {24'h0, s_rsp[0]}, 32'h90);
      chk("b2b_r1", {24'h0, s_rsp[1]}, 32'h91);
      chk("b2b_r2", {24'h0, s_rsp[2]}, 32'h92);
      chk("b2b_r3", {24'h0, s_rsp[3]}, 32'h80);
      chk("b2b_cyc", {s_rcyc[0][7:0], s_rcyc[1][7:0], s_rcyc[2][7:0], s_rcyc[3][7:0]}, 32'h02030405);
    end

    // rsp_ready low for 3 cycles
    s_addr[0] = 32'h0001_0C04; s_addr[1] = 32'h0000_0100; s_addr[2] = 32'h0001_0400;
    s_n = 3; s_rdy = 16'b1111_1111_1111_0001;
    stream(9);
    chk("stall_rr1", {31'h0, s_rr[1]}, 32'h1);
    chk("stall_rr2", {30'h0, s_rr[2], s_rr[3]}, 32'h0);
    chk("stall_acc", s_acc[2], 2);
    chk("stall_stable", s_unstable, 0);
    chk("stall_count", s_rsp.size(), 3);
    if (s_rsp.size() == 3)
      chk("stall_order", {8'h0, s_rsp[0], s_rsp[1], s_rsp[2]}, 32'h00938091);

    // overlap: entry 2 = 0..0x1_0000, lower index wins
    cfg_wr(3'd2, 2'd1, 32'h0001_0000, 1'b0, err);
    chk("ovl_err", {31'h0, err}, 32'h0);
    req_chk("ovl_low", 32'h0000_0100, 8'h80);
    req_chk("ovl_e2", 32'h0000_9000, 8'hA0);

    // end == all-ones includes the top address
    cfg_wr(3'd3, 2'd0, 32'hFFFF_F000, 1'b0, err);
    cfg_wr(3'd3, 2'd1, 32'hFFFF_FFFF, 1'b0, err);
    req_chk("top_addr", 32'hFFFF_FFFF, 8'hB0);

    // out-of-range index
    cfg_wr(3'd7, 2'd0, 32'h0, 1'b0, err);
    chk("idx_oor_err", {31'h0, err}, 32'h1);
    @(posedge clk); #1;
    chk("err_pulse", {31'h0, cfg_err}, 32'h0);

    // entry 2 reprogrammed; same-cycle request sees old end, next one the new
    cfg_wr(3'd2, 2'd0, 32'h0009_0000, 1'b0, err);
    cfg_wr(3'd2, 2'd2, 32'h0000_002A, 1'b0, err);
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0009_0800;
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_sel = 2'd1; cfg_wdata = 32'h0009_8000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("cfg_same_cyc", {23'h0, bus.rsp_valid, cur_rsp()}, 32'h100);
    @(posedge clk); #1;
    chk("cfg_next_cyc", {23'h0, bus.rsp_valid, cur_rsp()}, 32'h1A2);
    @(posedge clk); #1;

    // write together with lock lands; later writes rejected
    cfg_wr(3'd2, 2'd2, 32'h0000_002C, 1'b1, err);
    chk("lock_wr_err", {31'h0, err}, 32'h0);
    chk("locked", {31'h0, locked}, 32'h1);
    req_chk("lock_wr_applied", 32'h0009_3000, 8'hA3);
    cfg_wr(3'd2, 2'd2, 32'h0000_002A, 1'b0, err);
    chk("locked_err", {31'h0, err}, 32'h1);
    @(posedge clk); #1;
    chk("locked_err_pulse", {31'h0, cfg_err}, 32'h0);
    req_chk("locked_unchanged", 32'h0009_3000, 8'hA3);
    cfg_wr(3'd0, 2'd3, 32'h0, 1'b0, err);
    chk("locked_sel3_ok", {31'h0, err}, 32'h0);

    // reset with two requests in flight
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'h0001_0C04;
    @(posedge clk); #1;
    bus.req_addr = 32'h0000_0100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("flight_full", {31'h0, bus.rsp_valid}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst2_locked", {31'h0, locked}, 32'h0);
    rst = 1'b0; #1;
    chk("rst2_req_ready", {31'h0, bus.req_ready}, 32'h1);
    bus.rsp_ready = 1'b1; nv = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.rsp_valid) nv++; end
    chk("rst2_flushed", nv, 0);
    req_chk("rst2_e2_gone", 32'h0009_0800, 8'h00);
    req_chk("rst2_default", 32'h0001_0C04, 8'h93);

    // miss log
    req_chk("log_m1", 32'h0000_9000, 8'h00);
    req_chk("log_m2", 32'h0000_A000, 8'h00);
    @(posedge clk); #1;
`ifdef ADAM_MMAP_MISS_LOG_EN
    chk("log_flag", {31'h0, miss_flag}, 32'h1);
    chk("log_addr", miss_addr, 32'h0000_9000);
    cfg_wr(3'd0, 2'd3, 32'h0, 1'b0, err);
    chk("log_clr_flag", {31'h0, miss_flag}, 32'h0);
    chk("log_clr_addr", miss_addr, 32'h0);
`else
    chk("nolog_flag", {31'h0, miss_flag}, 32'h0);
    chk("nolog_addr", miss_addr, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
